// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming 3x3 Sobel edge filter.
package sobel_pkg;

  localparam int unsigned SIZE_WORD = 8;
  localparam int unsigned GRAD_W    = SIZE_WORD + 3;

  typedef logic        [SIZE_WORD-1:0] pixel_t;
  typedef logic signed [GRAD_W-1:0]    grad_t;
  typedef logic        [GRAD_W-1:0]    mag_t;

  // Window taps indexed [row][col]; row 0 is the top line, col 0 the left column.
  typedef pixel_t [2:0][2:0] window_t;

  localparam pixel_t PIXEL_MAX = '1;

  // Zero-extend an unsigned pixel into the signed gradient domain.
  function automatic grad_t widen(pixel_t p);
    return grad_t'({3'b000, p});
  endfunction

  // Gradients never reach the most negative code, so negation cannot overflow.
  function automatic mag_t absGrad(grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

endpackage

// File: rtl/sobel_filter_if.sv
// Pixel stream bus of the Sobel filter: raw pixel in, edge magnitude out.
interface sobel_filter_if;
  import sobel_pkg::*;

  pixel_t inputPixel;
  pixel_t outputPixel;

  modport master (output inputPixel, input outputPixel);
  modport slave  (input inputPixel, output outputPixel);

endinterface

// File: rtl/sobel_window.sv
// Two-lines-plus-three-pixels delay line that presents a 3x3 pixel window.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 8
) (
  input  logic    clock,
  input  logic    reset,
  input  pixel_t  inputPixel,
  output window_t window
);

  localparam int unsigned DEPTH = 2 * IMG_WIDTH + 3;

  if (IMG_WIDTH < 3) begin : gWidthCheck
    $error("sobel_window: IMG_WIDTH must be at least 3");
  end

  pixel_t sr [DEPTH];

  // Every entry shifts each cycle; reset discards all history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        sr[i] <= '0;
      end
    end else begin
      sr[0] <= inputPixel;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign window[0][0] = sr[2*IMG_WIDTH+2];
  assign window[0][1] = sr[2*IMG_WIDTH+1];
  assign window[0][2] = sr[2*IMG_WIDTH];
  assign window[1][0] = sr[IMG_WIDTH+2];
  assign window[1][1] = sr[IMG_WIDTH+1];
  assign window[1][2] = sr[IMG_WIDTH];
  assign window[2][0] = sr[2];
  assign window[2][1] = sr[1];
  assign window[2][2] = sr[0];

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge-magnitude filter, one pixel per clock.
// Define SOBEL_THRESHOLD_EN to emit a binary edge map (mag >= THRESHOLD) instead of saturated magnitude.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 8,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic           clock,
  input  logic           reset,
  sobel_filter_if.slave  bus
);

  if (THRESHOLD > (2 ** GRAD_W) - 1) begin : gThresholdCheck
    $error("sobel_filter: THRESHOLD exceeds the magnitude range");
  end

  window_t window;
  grad_t   gradX;
  grad_t   gradY;
  mag_t    magnitude;
  pixel_t  nextPixel;

  sobel_window #(
    .IMG_WIDTH (IMG_WIDTH)
  ) uWindow (
    .clock      (clock),
    .reset      (reset),
    .inputPixel (bus.inputPixel),
    .window     (window)
  );

  // Gradient, magnitude and output mapping all settle within one cycle.
  always_comb begin
    gradX = (widen(window[0][2]) + (widen(window[1][2]) <<< 1) + widen(window[2][2]))
          - (widen(window[0][0]) + (widen(window[1][0]) <<< 1) + widen(window[2][0]));
    gradY = (widen(window[2][0]) + (widen(window[2][1]) <<< 1) + widen(window[2][2]))
          - (widen(window[0][0]) + (widen(window[0][1]) <<< 1) + widen(window[0][2]));
    magnitude = absGrad(gradX) + absGrad(gradY);
`ifdef SOBEL_THRESHOLD_EN
    nextPixel = (magnitude >= mag_t'(THRESHOLD)) ? PIXEL_MAX : '0;
`else
    nextPixel = (magnitude > mag_t'(PIXEL_MAX)) ? PIXEL_MAX : pixel_t'(magnitude);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.outputPixel <= '0;
    end else begin
      bus.outputPixel <= nextPixel;
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// Directed bench for sobel_filter: table-driven streams plus reset corner sequences.
module tb_sobel_filter;
  import sobel_pkg::*;

  localparam int unsigned W = 8;

  typedef struct {
    pixel_t pix;
    pixel_t expOut;
    bit     chk;
    int     phase;
  } vec_t;

`ifdef SOBEL_THRESHOLD_EN
  localparam pixel_t SMALL_HI = 8'd0;
  localparam pixel_t LARGE_HI = 8'd255;
`else
  localparam pixel_t SMALL_HI = 8'd20;
  localparam pixel_t LARGE_HI = 8'd200;
`endif

  logic clock;
  logic reset;
  int   nCompared;
  int   nMismatched;
  vec_t vecs[$];

  string  phaseName [7] = '{"zeroAfterReset", "flat77", "flush", "impulse10",
                            "impulse100", "saturation", "flushEnd"};
  bit     impHit [22] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0,
                          1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
  pixel_t satExp [10] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0,
                          8'd0, 8'd255, 8'd255, 8'd0, 8'd0};

  sobel_filter_if bus ();

  sobel_filter #(
    .IMG_WIDTH (W),
    .THRESHOLD (128)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input pixel_t act, input pixel_t exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input pixel_t p, input pixel_t e, input bit c, input int ph);
    vec_t v;
    v.pix    = p;
    v.expOut = e;
    v.chk    = c;
    v.phase  = ph;
    vecs.push_back(v);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;

    push(8'd0, 8'd0, 1'b1, 0);
    push(8'd0, 8'd0, 1'b1, 0);
    push(8'd0, 8'd0, 1'b1, 0);
    push(8'd0, 8'd0, 1'b1, 0);
    push(8'd0, 8'd0, 1'b1, 0);
    push(8'd0, 8'd0, 1'b1, 0);
    for (int e = 1; e <= 28; e++) push(8'd77, 8'd0, e >= 20, 1);
    for (int f = 1; f <= 21; f++) push(8'd0, 8'd0, f >= 20, 2);
    for (int i = 0; i < 22; i++) push((i == 0) ? 8'd10 : 8'd0, impHit[i] ? SMALL_HI : 8'd0, 1'b1, 3);
    for (int i = 0; i < 22; i++) push((i == 0) ? 8'd100 : 8'd0, impHit[i] ? LARGE_HI : 8'd0, 1'b1, 4);
    for (int e = 1; e <= 29; e++)
      push((((e - 1) % 8) >= 4) ? 8'd255 : 8'd0, (e >= 20) ? satExp[e - 20] : 8'd0, e >= 20, 5);
    for (int f = 1; f <= 21; f++) push(8'd0, 8'd0, f >= 20, 6);

    // Reset held low with noisy input and a running clock.
    reset = 1'b1;
    bus.inputPixel = '0;
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.inputPixel = pixel_t'($urandom_range(0, 255));
      @(posedge clock);
      #1 check($sformatf("inReset[%0d]", i), bus.outputPixel, 8'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    bus.inputPixel = '0;

    foreach (vecs[idx]) begin
      @(negedge clock);
      bus.inputPixel = vecs[idx].pix;
      @(posedge clock);
      #1;
      if (vecs[idx].chk)
        check($sformatf("%s[%0d]", phaseName[vecs[idx].phase], idx), bus.outputPixel, vecs[idx].expOut);
    end

    // Mid-stream async reset: output must clear before the next edge and history must vanish.
    @(negedge clock);
    bus.inputPixel = 8'd200;
    @(negedge clock);
    bus.inputPixel = 8'd0;
    @(posedge clock);
    #1 check("preResetHigh", bus.outputPixel, 8'd255);
    #2 reset = 1'b0;
    #1 check("asyncClear", bus.outputPixel, 8'd0);
    @(posedge clock);
    #1 check("heldInReset", bus.outputPixel, 8'd0);
    @(negedge clock);
    reset = 1'b1;
    bus.inputPixel = '0;
    for (int i = 0; i < 22; i++) begin
      @(posedge clock);
      #1 check($sformatf("postReset[%0d]", i), bus.outputPixel, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
